pe_relay_tile: RTL and testbench
================================

# pe_relay_tile

Four-direction elastic relay tile for the PE mesh. It replaces the plain per-direction pass-through register with a DEPTH-entry FIFO per direction and a valid/ready handshake, so neighbouring tiles can apply backpressure without losing data. `ap_start` gates all four channels. Each channel is independent: data entering from a side leaves toward the same-named output.

## Interface
- EAST_WIDTH, 131: east channel data width.
- WEST_WIDTH, 130: west channel data width.
- NORTH_WIDTH, 167: north channel data width.
- SOUTH_WIDTH, 324: south channel data width.
- DEPTH, 2: entries per channel FIFO; must be a power of 2 and ≥ 2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived).

Channel index for all 4-bit handshake vectors: 0=east, 1=west, 2=north, 3=south.
- clk  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ap_start  input  1  channel enable; low freezes all channels.
- in_from_east  input  EAST_WIDTH  east ingress data.
- in_from_west  input  WEST_WIDTH  west ingress data.
- in_from_north  input  NORTH_WIDTH  north ingress data.
- in_from_south  input  SOUTH_WIDTH  south ingress data.
- in_valid  input  4  ingress valid, per channel.
- in_ready  output  4  ingress ready, per channel.
- out_to_east  output  EAST_WIDTH  east egress data (FIFO head).
- out_to_west  output  WEST_WIDTH  west egress data.
- out_to_north  output  NORTH_WIDTH  north egress data.
- out_to_south  output  SOUTH_WIDTH  south egress data.
- out_valid  output  4  egress valid, per channel.
- out_ready  input  4  egress ready, per channel.

## Operation
- Per channel state: storage array of DEPTH words, write pointer `wp` and read pointer `rp` (each $clog2(DEPTH) bits, natural wrap), and occupancy `cnt` (CNT_W bits, range 0..DEPTH).
- Handshake signals:
  - in_ready[i] = ap_start && cnt < DEPTH.
  - out_valid[i] = ap_start && cnt != 0.
- Transfers:
  - push = in_valid & in_ready: write mem[wp], then wp+1.
  - pop = out_valid & out_ready: rp+1.
- Counter update:
  - cnt+1 on push only; cnt-1 on pop only.
  - cnt unchanged on push and pop in the same cycle. This is legal whenever 0 < cnt < DEPTH.
- out_to_* = mem[rp], combinational from registered state. The value is held while out_valid is low.
- ap_start low:
  - in_ready = 0 and out_valid = 0; no push or pop occurs.
  - cnt, pointers and storage are held.
  - out_to_* keeps presenting mem[rp].
- Channels never interact. A stall on one channel does not affect the others.
- The upstream must hold data stable while valid is high and ready is low. The block does not check this.

## Timing
- Reset, asynchronous on reset_n low, effective immediately including mid-transfer:
  - cnt = 0, wp = rp = 0, all storage words = 0.
  - Therefore out_to_* = 0, out_valid = 0 and in_ready = 0 (ready stays low until ap_start is high).
- Release of reset_n is synchronous to clk. The first push is possible on the first rising edge after release with ap_start high.
- Latency: a push at edge t into an empty channel gives out_valid high and the data on out_to_* after edge t. That is 1 cycle; there is no combinational bypass from in to out.
- Throughput: 1 word/cycle per channel while 0 < cnt < DEPTH.
- Without the macro, a full channel accepts a new word only on the cycle after a pop.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Configuration
- PE_RELAY_FULL_BYPASS_EN:
  - Defined: in_ready[i] = ap_start && (cnt < DEPTH || out_ready[i]). A full channel accepts a push in the same cycle as a pop; cnt stays DEPTH and full-rate streaming is sustained at cnt = DEPTH. This adds a combinational out_ready→in_ready path.
  - Undefined: in_ready is as in Operation and depends only on registered state, with no ready path through the tile.

## Test plan
- Reset: drive reset_n low mid-stream with cnt = 2 on east. Required immediately: out_to_* = 0, out_valid = 4'b0000 and in_ready = 4'b0000. After release with ap_start = 1: in_ready = 4'b1111.
- Latency: push east 131'h5A5 at edge t with out_ready = 0. Required: out_valid[0] = 1 and out_to_east = 131'h5A5 after edge t. All other out_valid bits stay 0.
- Fill with DEPTH = 2, out_ready = 0:
  - Push north 1, 2, 3 on consecutive cycles.
  - Required: in_ready[2] = 0 after the second push; word 3 not accepted.
  - Raise out_ready: required pops 1 then 2, in order.
- Simultaneous push/pop on south at cnt = 1 for 8 cycles with data 0..7. Required: cnt stays 1, out sequence is continuous and pointers wrap with no bubble.
- Freeze: with cnt = 1 on west, drop ap_start for 3 cycles while in_valid = out_ready = 1. Required: in_ready[1] = 0, out_valid[1] = 0 and out_to_west held. Resume delivers the same word.
- Macro: at cnt = DEPTH with out_ready = 1 and in_valid = 1.
  - Defined: in_ready = 1 and cnt stays DEPTH.
  - Undefined: in_ready = 0.

Source files
------------

// File: rtl/pe_relay_tile.sv
// pe_relay_tile: four-direction elastic relay tile, one valid/ready FIFO per direction.
//
// Ports:
//   clk, reset_n (async active-low), ap_start (enable for all channels)
//   in_from_{east,west,north,south} / in_valid[3:0] / in_ready[3:0]     : ingress
//   out_to_{east,west,north,south}  / out_valid[3:0] / out_ready[3:0]   : egress
//   Channel index: 0=east, 1=west, 2=north, 3=south.
// Optional feature macro: PE_RELAY_FULL_BYPASS_EN (a full channel accepts a push
// in the same cycle as a pop, adding an out_ready -> in_ready path).

module pe_relay_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ap_start,
  input  logic [W-1:0] i_in_data,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_out_valid,
  input  logic         i_out_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  assign w_full = r_cnt == CNT_W'(DEPTH);
`ifdef PE_RELAY_FULL_BYPASS_EN
  // When full, a pop this cycle frees the head slot, which is the one wp points at.
  assign o_in_ready = ap_start && (!w_full || i_out_ready);
`else
  assign o_in_ready = ap_start && !w_full;
`endif
  assign o_out_valid = ap_start && r_cnt != '0;
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;
  // Head word is always presented, even while out_valid is low.
  assign o_out_data  = r_mem[r_rp];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_in_data;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

module pe_relay_tile #(
  parameter int EAST_WIDTH  = 131,
  parameter int WEST_WIDTH  = 130,
  parameter int NORTH_WIDTH = 167,
  parameter int SOUTH_WIDTH = 324,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ap_start,
  input  logic [EAST_WIDTH-1:0]  in_from_east,
  input  logic [WEST_WIDTH-1:0]  in_from_west,
  input  logic [NORTH_WIDTH-1:0] in_from_north,
  input  logic [SOUTH_WIDTH-1:0] in_from_south,
  input  logic [3:0]             in_valid,
  output logic [3:0]             in_ready,
  output logic [EAST_WIDTH-1:0]  out_to_east,
  output logic [WEST_WIDTH-1:0]  out_to_west,
  output logic [NORTH_WIDTH-1:0] out_to_north,
  output logic [SOUTH_WIDTH-1:0] out_to_south,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready
);
  pe_relay_fifo #(.W(EAST_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_east (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .i_in_data(in_from_east), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
    .o_out_data(out_to_east), .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0])
  );
  pe_relay_fifo #(.W(WEST_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_west (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .i_in_data(in_from_west), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
    .o_out_data(out_to_west), .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1])
  );
  pe_relay_fifo #(.W(NORTH_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_north (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .i_in_data(in_from_north), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
    .o_out_data(out_to_north), .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2])
  );
  pe_relay_fifo #(.W(SOUTH_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_south (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .i_in_data(in_from_south), .i_in_valid(in_valid[3]), .o_in_ready(in_ready[3]),
    .o_out_data(out_to_south), .o_out_valid(out_valid[3]), .i_out_ready(out_ready[3])
  );
endmodule

// File: tb/tb_pe_relay_tile.sv
// tb_pe_relay_tile: directed self-checking bench for pe_relay_tile (DEPTH = 2).
module tb_pe_relay_tile;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         ap_start;
  logic [130:0] e_in;
  logic [129:0] w_in;
  logic [166:0] n_in;
  logic [323:0] s_in;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [130:0] e_out;
  logic [129:0] w_out;
  logic [166:0] n_out;
  logic [323:0] s_out;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         exp_bypass;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_relay_tile dut (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .in_from_east(e_in), .in_from_west(w_in), .in_from_north(n_in), .in_from_south(s_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_to_east(e_out), .out_to_west(w_out), .out_to_north(n_out), .out_to_south(s_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; ap_start = 1'b0; in_valid = '0; out_ready = '0;
    e_in = '0; w_in = '0; n_in = '0; s_in = '0;
    @(negedge clk);
    reset_n = 1'b1; ap_start = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    checks++; if (in_ready !== 4'b1111) begin failures++; $display("FAIL reset_in_ready got=%b exp=1111", in_ready); end
    @(negedge clk);
    e_in = 131'h11; in_valid = 4'b0001;
    @(negedge clk);
    e_in = 131'h22;
    @(negedge clk);
    in_valid = 4'b0000;
    checks++; if (e_out !== 131'h11) begin failures++; $display("FAIL reset_prefill got=%h exp=11", e_out); end
    #2;
    reset_n = 1'b0; ap_start = 1'b0;
    #1;
    checks++; if (e_out !== 131'h0 || w_out !== '0 || n_out !== '0 || s_out !== '0) begin failures++; $display("FAIL reset_async_data got=%h exp=0", e_out); end
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_async_valid got=%b exp=0000", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_async_ready got=%b exp=0000", in_ready); end
    @(negedge clk);
    reset_n = 1'b1; ap_start = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b1111) begin failures++; $display("FAIL reset_release_ready got=%b exp=1111", in_ready); end
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_release_valid got=%b exp=0000", out_valid); end
  endtask

  task automatic test_latency();
    do_reset();
    e_in = 131'h5A5; in_valid = 4'b0001;
    #1;
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL lat_no_bypass got=%b exp=0000", out_valid); end
    @(negedge clk);
    in_valid = 4'b0000;
    checks++; if (out_valid !== 4'b0001) begin failures++; $display("FAIL lat_valid got=%b exp=0001", out_valid); end
    checks++; if (e_out !== 131'h5A5) begin failures++; $display("FAIL lat_data got=%h exp=5a5", e_out); end
  endtask

  task automatic test_fill();
    do_reset();
    n_in = 167'd1; in_valid = 4'b0100;
    @(negedge clk);
    checks++; if (in_ready[2] !== 1'b1) begin failures++; $display("FAIL fill_ready1 got=%b exp=1", in_ready[2]); end
    n_in = 167'd2;
    @(negedge clk);
    checks++; if (in_ready[2] !== 1'b0) begin failures++; $display("FAIL fill_full got=%b exp=0", in_ready[2]); end
    n_in = 167'd3;
    @(negedge clk);
    checks++; if (in_ready[2] !== 1'b0) begin failures++; $display("FAIL fill_still_full got=%b exp=0", in_ready[2]); end
    checks++; if (n_out !== 167'd1) begin failures++; $display("FAIL fill_head got=%0d exp=1", n_out); end
    in_valid = 4'b0000; out_ready = 4'b0100;
    @(negedge clk);
    checks++; if (n_out !== 167'd2 || out_valid[2] !== 1'b1) begin failures++; $display("FAIL fill_pop2 got=%0d/%b exp=2/1", n_out, out_valid[2]); end
    @(negedge clk);
    checks++; if (out_valid[2] !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", out_valid[2]); end
    out_ready = 4'b0000;
  endtask

  task automatic test_back_to_back();
    do_reset();
    s_in = 324'd0; in_valid = 4'b1000;
    @(negedge clk);
    out_ready = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      checks++; if (s_out !== 324'(i) || out_valid[3] !== 1'b1 || in_ready[3] !== 1'b1) begin failures++; $display("FAIL b2b_%0d got=%0d v=%b r=%b exp=%0d v=1 r=1", i, s_out, out_valid[3], in_ready[3], i); end
      s_in = 324'(i + 1);
      @(negedge clk);
    end
    in_valid = 4'b0000; out_ready = 4'b0000;
    checks++; if (s_out !== 324'd8 || out_valid !== 4'b1000) begin failures++; $display("FAIL b2b_tail got=%0d v=%b exp=8 v=1000", s_out, out_valid); end
  endtask

  task automatic test_freeze();
    do_reset();
    w_in = 130'h3C3C; in_valid = 4'b0010;
    @(negedge clk);
    w_in = 130'h77; out_ready = 4'b0010; ap_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b0 || w_out !== 130'h3C3C) begin failures++; $display("FAIL freeze_%0d got r=%b v=%b d=%h exp r=0 v=0 d=3c3c", i, in_ready[1], out_valid[1], w_out); end
      @(negedge clk);
    end
    ap_start = 1'b1; in_valid = 4'b0000;
    #1;
    checks++; if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b1 || w_out !== 130'h3C3C) begin failures++; $display("FAIL freeze_resume got v=%b r=%b d=%h exp v=1 r=1 d=3c3c", out_valid[1], in_ready[1], w_out); end
    @(negedge clk);
    out_ready = 4'b0000;
    checks++; if (out_valid[1] !== 1'b0) begin failures++; $display("FAIL freeze_drained got=%b exp=0", out_valid[1]); end
  endtask

  task automatic test_full_bypass();
    do_reset();
    e_in = 131'd1; in_valid = 4'b0001;
    @(negedge clk);
    e_in = 131'd2;
    @(negedge clk);
    e_in = 131'd3; out_ready = 4'b0001;
    #1;
    checks++; if (in_ready[0] !== exp_bypass) begin failures++; $display("FAIL bypass_ready got=%b exp=%b", in_ready[0], exp_bypass); end
    checks++; if (out_valid[0] !== 1'b1 || e_out !== 131'd1) begin failures++; $display("FAIL bypass_head got v=%b d=%0d exp v=1 d=1", out_valid[0], e_out); end
    @(negedge clk);
    checks++; if (e_out !== 131'd2) begin failures++; $display("FAIL bypass_pop got=%0d exp=2", e_out); end
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL bypass_after got=%b exp=1", in_ready[0]); end
    in_valid = 4'b0000; out_ready = 4'b0000;
  endtask

  initial begin
`ifdef PE_RELAY_FULL_BYPASS_EN
    exp_bypass = 1'b1;
`else
    exp_bypass = 1'b0;
`endif
    reset_n = 1'b0; ap_start = 1'b0; in_valid = '0; out_ready = '0;
    e_in = '0; w_in = '0; n_in = '0; s_in = '0;
    #1;
    checks++; if (out_valid !== 4'b0000 || in_ready !== 4'b0000 || e_out !== '0) begin failures++; $display("FAIL power_on got v=%b r=%b exp 0000/0000", out_valid, in_ready); end
    test_reset();
    test_latency();
    test_fill();
    test_back_to_back();
    test_freeze();
    test_full_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
